// File: rtl/dp_pkg.sv
// Shared constants and types for the 16-bit execution datapath.
package dp_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PC_W      = 8;
  localparam int unsigned NREGS     = 8;
  localparam int unsigned REG_IDX_W = 3;

  // Write-back source select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // Shifter operation on B
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // Status flags as held in the status register
  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/datapath16_if.sv
// Controller <-> datapath strobe/data bundle.
interface datapath16_if
  import dp_pkg::*;
();

  logic [REG_IDX_W-1:0] readnum;
  logic [REG_IDX_W-1:0] writenum;
  logic                 write;
  logic [1:0]           vsel;
  logic                 loada;
  logic                 loadb;
  logic                 asel;
  logic                 bsel;
  logic [1:0]           shift;
  logic [1:0]           alu_op;
  logic                 loadc;
  logic                 loads;
  logic [DATA_W-1:0]    sximm8;
  logic [DATA_W-1:0]    sximm5;
  logic [DATA_W-1:0]    mdata;
  logic [PC_W-1:0]      pc;
  logic [DATA_W-1:0]    datapath_out;
  logic                 z_out;
  logic                 n_out;
  logic                 v_out;

  // Controller side: drives strobes and operands, observes result/status
  modport master (
    output readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           shift, alu_op, loadc, loads, sximm8, sximm5, mdata, pc,
    input  datapath_out, z_out, n_out, v_out
  );

  // Datapath side
  modport slave (
    input  readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           shift, alu_op, loadc, loads, sximm8, sximm5, mdata, pc,
    output datapath_out, z_out, n_out, v_out
  );

endinterface

// File: rtl/dp_regfile.sv
// 8x16 register file: async clear, synchronous write, combinational read.
module dp_regfile
  import dp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] readnum_i,
  input  logic [REG_IDX_W-1:0] writenum_i,
  input  logic                 write_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Register array; a same-cycle read of the written index sees the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else if (write_i) begin
      regs_q[writenum_i] <= wdata_i;
    end
  end

  assign rdata_o = regs_q[readnum_i];

endmodule

// File: rtl/datapath16.sv
// 16-bit execution datapath: regfile, A/B operands, shifter, ALU, C and status.
module datapath16
  import dp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  datapath16_if.slave  dp
);

  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  flags_t            status_q, status_d;
  logic [DATA_W-1:0] sh_out;
  logic [DATA_W-1:0] ain;
  logic [DATA_W-1:0] bin;
  logic [DATA_W-1:0] alu_res;
  flags_t            alu_flags;

  // Write-back source mux; C is the registered value, so a same-cycle loadc writes old C
  always_comb begin
    wb_data = c_q;
    case (dp.vsel)
      VSEL_C:     wb_data = c_q;
      VSEL_PC:    wb_data = DATA_W'(dp.pc);
      VSEL_IMM8:  wb_data = dp.sximm8;
      VSEL_MDATA: wb_data = dp.mdata;
      default:    wb_data = c_q;
    endcase
  end

  dp_regfile u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .readnum_i  (dp.readnum),
    .writenum_i (dp.writenum),
    .write_i    (dp.write),
    .wdata_i    (wb_data),
    .rdata_o    (rdata)
  );

  // Shifter on B
  always_comb begin
    sh_out = b_q;
    case (dp.shift)
      SH_NONE: sh_out = b_q;
      SH_SHL:  sh_out = {b_q[DATA_W-2:0], 1'b0};
      SH_LSR:  sh_out = {1'b0, b_q[DATA_W-1:1]};
      SH_ASR:  sh_out = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: sh_out = b_q;
    endcase
  end

  assign ain = dp.asel ? '0 : a_q;
  assign bin = dp.bsel ? dp.sximm5 : sh_out;

  // ALU and its flags; overflow only meaningful for add/sub
  always_comb begin
    alu_res     = '0;
    alu_flags   = '0;
    case (dp.alu_op)
      ALU_ADD: begin
        alu_res     = ain + bin;
        alu_flags.v = (ain[DATA_W-1] == bin[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != ain[DATA_W-1]);
      end
      ALU_SUB: begin
        alu_res     = ain - bin;
        alu_flags.v = (ain[DATA_W-1] != bin[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != ain[DATA_W-1]);
      end
      ALU_AND: alu_res = ain & bin;
      ALU_NOT: alu_res = ~bin;
      default: alu_res = '0;
    endcase
    alu_flags.z = (alu_res == '0);
    alu_flags.n = alu_res[DATA_W-1];
  end

  // Next-state for operand, result and status registers
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    status_d = status_q;
    if (dp.loada) a_d = rdata;
    if (dp.loadb) b_d = rdata;
    if (dp.loadc) c_d = alu_res;
    if (dp.loads) status_d = alu_flags;
  end

  // Operand, result and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign dp.datapath_out = c_q;
  assign dp.z_out        = status_q.z;
  assign dp.n_out        = status_q.n;
  assign dp.v_out        = status_q.v;

endmodule

// File: tb/tb_datapath16.sv
// Scoreboard bench for datapath16: stimulus pushes expected C/flags, monitor compares.
module tb_datapath16;
  import dp_pkg::*;

  logic clk;
  logic rst_n;

  datapath16_if dp_if ();

  datapath16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [2:0]  f;   // {z,n,v}
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [2:0] ef;   // expected status flags as tracked by the bench

  // Monitor: compare one expected observation per falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (dp_if.datapath_out !== e.d ||
          {dp_if.z_out, dp_if.n_out, dp_if.v_out} !== e.f) begin
        failures++;
        $display("FAIL %s: got out=%h znv=%b, expected out=%h znv=%b",
                 e.name, dp_if.datapath_out,
                 {dp_if.z_out, dp_if.n_out, dp_if.v_out}, e.d, e.f);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, checks=%0d", checks);
    $fatal(1);
  end

  task automatic idle();
    dp_if.write = 1'b0;
    dp_if.loada = 1'b0;
    dp_if.loadb = 1'b0;
    dp_if.loadc = 1'b0;
    dp_if.loads = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_out(input string name, input logic [15:0] d);
    exp_t e;
    e.name = name;
    e.d    = d;
    e.f    = ef;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic wr_imm(input logic [2:0] r, input logic [15:0] v);
    dp_if.writenum = r;
    dp_if.vsel     = VSEL_IMM8;
    dp_if.sximm8   = v;
    dp_if.write    = 1'b1;
    tick();
  endtask

  task automatic ld_a(input logic [2:0] r);
    dp_if.readnum = r;
    dp_if.loada   = 1'b1;
    tick();
  endtask

  task automatic ld_b(input logic [2:0] r);
    dp_if.readnum = r;
    dp_if.loadb   = 1'b1;
    tick();
  endtask

  task automatic op(input logic as, input logic bs, input logic [1:0] sh,
                    input logic [1:0] aop, input logic lc, input logic ls,
                    input logic [15:0] imm5);
    dp_if.asel   = as;
    dp_if.bsel   = bs;
    dp_if.shift  = sh;
    dp_if.alu_op = aop;
    dp_if.loadc  = lc;
    dp_if.loads  = ls;
    dp_if.sximm5 = imm5;
    tick();
  endtask

  // Observe R[r] through A + sximm5 into C without touching status
  task automatic read_reg(input string name, input logic [2:0] r,
                          input logic [15:0] off, input logic [15:0] exp_d);
    ld_a(r);
    op(1'b0, 1'b1, SH_NONE, ALU_ADD, 1'b1, 1'b0, off);
    expect_out(name, exp_d);
  endtask

  task automatic run(input string name, input logic [2:0] ra, input logic [2:0] rb,
                     input logic [1:0] sh, input logic [1:0] aop,
                     input logic lc, input logic ls,
                     input logic [15:0] exp_d, input logic [2:0] exp_f);
    ld_a(ra);
    ld_b(rb);
    op(1'b0, 1'b0, sh, aop, lc, ls, 16'h0000);
    if (ls) ef = exp_f;
    expect_out(name, exp_d);
  endtask

  initial begin
    rst_n          = 1'b0;
    ef             = 3'b000;
    dp_if.readnum  = '0;
    dp_if.writenum = '0;
    dp_if.vsel     = VSEL_C;
    dp_if.asel     = 1'b0;
    dp_if.bsel     = 1'b0;
    dp_if.shift    = SH_NONE;
    dp_if.alu_op   = ALU_ADD;
    dp_if.sximm8   = '0;
    dp_if.sximm5   = '0;
    dp_if.mdata    = '0;
    dp_if.pc       = '0;
    idle();

    expect_out("reset_initial", 16'h0000);
    rst_n = 1'b1;

    // Populate registers and C so the async reset has something to clear
    for (int i = 0; i < 8; i++) wr_imm(3'(i), 16'(16'h0011 * (i + 1)));
    ld_a(3'd7);
    op(1'b0, 1'b1, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h0000);
    ef = 3'b000;
    expect_out("pre_reset_c", 16'h0088);

    // Reset mid-cycle with a load pending
    dp_if.asel   = 1'b1;
    dp_if.bsel   = 1'b1;
    dp_if.sximm5 = 16'h000F;
    dp_if.alu_op = ALU_ADD;
    dp_if.loadc  = 1'b1;
    dp_if.loads  = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dp_if.datapath_out, dp_if.z_out, dp_if.n_out, dp_if.v_out} !== 19'h0) begin
      failures++;
      $display("FAIL reset_immediate: out=%h znv=%b", dp_if.datapath_out,
               {dp_if.z_out, dp_if.n_out, dp_if.v_out});
    end
    ef    = 3'b000;
    expect_out("reset_async", 16'h0000);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    expect_out("reset_discard_load", 16'h0000);
    for (int k = 0; k < 8; k++) read_reg($sformatf("reset_r%0d", k), 3'(k), 16'h0001, 16'h0001);

    // Immediate move
    wr_imm(3'd0, 16'h0007);
    ld_b(3'd0);
    op(1'b1, 1'b0, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h0000);
    ef = 3'b000;
    expect_out("mov_imm", 16'h0007);

    // Add with shift, write-back of C
    wr_imm(3'd1, 16'h0007);
    wr_imm(3'd2, 16'h0002);
    run("add_shl", 3'd1, 3'd2, SH_SHL, ALU_ADD, 1'b1, 1'b1, 16'h000B, 3'b000);
    dp_if.writenum = 3'd3;
    dp_if.vsel     = VSEL_C;
    dp_if.write    = 1'b1;
    tick();
    read_reg("wb_c_r3", 3'd3, 16'h0000, 16'h000B);

    // Simultaneous loadc and write-back: register gets old C
    ld_a(3'd1);
    dp_if.writenum = 3'd4;
    dp_if.vsel     = VSEL_C;
    dp_if.write    = 1'b1;
    op(1'b0, 1'b1, SH_NONE, ALU_ADD, 1'b1, 1'b0, 16'h0000);
    expect_out("loadc_with_wb", 16'h0007);
    read_reg("wb_old_c_r4", 3'd4, 16'h0000, 16'h000B);

    // Read of a register written the same cycle returns old value
    dp_if.writenum = 3'd5;
    dp_if.vsel     = VSEL_IMM8;
    dp_if.sximm8   = 16'h0055;
    dp_if.write    = 1'b1;
    dp_if.readnum  = 3'd5;
    dp_if.loada    = 1'b1;
    tick();
    op(1'b0, 1'b1, SH_NONE, ALU_ADD, 1'b1, 1'b0, 16'h0000);
    expect_out("read_during_write", 16'h0000);
    read_reg("write_visible_r5", 3'd5, 16'h0000, 16'h0055);

    // Overflow cases
    wr_imm(3'd6, 16'h7FFF);
    wr_imm(3'd7, 16'h0001);
    run("add_ovf", 3'd6, 3'd7, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h8000, 3'b011);
    wr_imm(3'd6, 16'h8000);
    run("sub_ovf", 3'd6, 3'd7, SH_NONE, ALU_SUB, 1'b1, 1'b1, 16'h7FFF, 3'b001);

    // Compare-equal: status only, C holds
    wr_imm(3'd6, 16'h0005);
    wr_imm(3'd7, 16'h0005);
    run("cmp_eq", 3'd6, 3'd7, SH_NONE, ALU_SUB, 1'b0, 1'b1, 16'h7FFF, 3'b100);

    // Negative difference and add wrapping to zero
    wr_imm(3'd6, 16'h0003);
    run("sub_neg", 3'd6, 3'd7, SH_NONE, ALU_SUB, 1'b1, 1'b1, 16'hFFFE, 3'b010);
    wr_imm(3'd6, 16'hFFFF);
    wr_imm(3'd7, 16'h0001);
    run("add_wrap_zero", 3'd6, 3'd7, SH_NONE, ALU_ADD, 1'b1, 1'b1, 16'h0000, 3'b100);

    // Logic ops
    wr_imm(3'd6, 16'hF0F0);
    wr_imm(3'd7, 16'h0FF0);
    run("and", 3'd6, 3'd7, SH_NONE, ALU_AND, 1'b1, 1'b1, 16'h00F0, 3'b000);
    wr_imm(3'd7, 16'h00FF);
    run("not", 3'd6, 3'd7, SH_NONE, ALU_NOT, 1'b1, 1'b1, 16'hFF00, 3'b010);

    // Shifts of 0x8002 added to zero
    wr_imm(3'd6, 16'h0000);
    wr_imm(3'd7, 16'h8002);
    run("asr", 3'd6, 3'd7, SH_ASR, ALU_ADD, 1'b1, 1'b1, 16'hC001, 3'b010);
    run("lsr", 3'd6, 3'd7, SH_LSR, ALU_ADD, 1'b1, 1'b1, 16'h4001, 3'b000);
    run("shl", 3'd6, 3'd7, SH_SHL, ALU_ADD, 1'b1, 1'b1, 16'h0004, 3'b000);

    // PC and memory-data write-back sources
    dp_if.writenum = 3'd2;
    dp_if.vsel     = VSEL_PC;
    dp_if.pc       = 8'h2A;
    dp_if.write    = 1'b1;
    tick();
    read_reg("wb_pc", 3'd2, 16'h0000, 16'h002A);
    dp_if.writenum = 3'd3;
    dp_if.vsel     = VSEL_MDATA;
    dp_if.mdata    = 16'hBEEF;
    dp_if.write    = 1'b1;
    tick();
    read_reg("wb_mdata", 3'd3, 16'h0000, 16'hBEEF);

    // Idle cycles: C and status hold
    dp_if.alu_op = ALU_NOT;
    dp_if.bsel   = 1'b1;
    dp_if.sximm5 = 16'h0000;
    tick();
    tick();
    expect_out("hold", 16'hBEEF);

    repeat (2) @(negedge clk);
    if (checks < 12) begin
      failures++;
      $display("FAIL check_count: only %0d checks ran", checks);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
